sig_dump: RTL and testbench
===========================

# sig_dump

Hardware signature dumper for the RV32I pipelined core's compliance flow. It snoops the data-memory store port for the completion write to `tohost`. It then reads every word of the signature region from data memory and transmits each word over a UART TX line as 8 lowercase hex ASCII characters plus a newline. This lets compliance runs on an FPGA board produce the same per-line `%08h` signature file as simulation. It sits beside the data BRAM, sharing a spare synchronous read port and tapping the core's store bus.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868 — clock cycles per UART bit (100 MHz / 115200 baud); must be ≥ 2.
- `TOHOST`, 32'h00005000 — byte address whose store of 1 triggers the dump.
- `SIG_BEGIN`, 32'h00005000 — first signature byte address (inclusive, word aligned).
- `SIG_END`, 32'h00008000 — end signature byte address (exclusive, word aligned).

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `st_en` in 1 — data-memory full-word store strobe from core.
- `st_addr` in 32 — store byte address.
- `st_data` in 32 — store data.
- `rd_en` out 1 — read strobe to BRAM read port.
- `rd_addr` out 32 — byte address of the read.
- `rd_data` in 32 — read data, valid the cycle after `rd_en`.
- `tx` out 1 — UART line, 8N1, idle high.
- `busy` out 1 — high from trigger until dump complete.
- `done` out 1 — sticky high after the last character's stop bit.

## Operation
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE: trigger when `st_en && st_addr==TOHOST && st_data==32'h1` is sampled at a rising edge.
  - All other stores are ignored.
  - On trigger, the word pointer loads `SIG_BEGIN`.
  - If `SIG_BEGIN >= SIG_END`, go directly to DONE; no characters are sent.
- READ: `rd_en=1` and `rd_addr=pointer` for exactly one cycle → WAIT.
- WAIT: capture `rd_data` into the shift word → SEND.
- SEND: emit 9 characters back-to-back.
  - First, nibbles [31:28] down to [3:0], each mapped 0–9 → 0x30–0x39 and a–f → 0x61–0x66.
  - Then 0x0A.
  - Each character is framed as: start bit 0, data bits 0–7 LSB first, stop bit 1. Each bit is held exactly `CLKS_PER_BIT` cycles.
  - After the stop bit of 0x0A, the pointer advances by 4 (32-bit add, wraps modulo 2^32). If the pointer is < `SIG_END`, go to READ; otherwise go to DONE.
- DONE: `done=1`, `busy=0`, `tx=1`. Held until reset; further triggers are ignored.
- Triggers arriving in READ/WAIT/SEND are ignored (no queueing, no restart).
- `busy` is 1 in READ, WAIT and SEND.

## Timing
- Reset values (asynchronous, immediate):
  - `tx=1`, `busy=0`, `done=0`, `rd_en=0`, `rd_addr=0`.
  - State is IDLE; the bit counter, character counter and baud counter are 0.
- Reset asserted mid-character aborts the frame; `tx` returns high immediately.
- Latency: trigger sampled at edge k → `rd_en` high in cycle k+1 → data captured at edge k+2 → start bit begins in cycle k+2 (after edge k+2).
- Per word: 2 idle-high cycles (READ, WAIT), then 90·`CLKS_PER_BIT` cycles of framed data.
- Total dump time for N words: N·(2 + 90·`CLKS_PER_BIT`) cycles.
- `rd_addr` holds its last value outside READ; `rd_data` is sampled only in WAIT.
- `done` rises on the edge ending the last stop bit (or on the edge after the trigger for an empty region).

## Test plan
- Basic dump: `CLKS_PER_BIT=4`, `SIG_BEGIN=0x10`, `SIG_END=0x18`, `TOHOST=0x20`; memory[0x10]=0xDEADBEEF, memory[0x14]=0x0000001A; store 1 to 0x20.
  - Required: UART decodes "deadbeef\n0000001a\n".
  - Required: exactly 2 `rd_en` pulses, at 0x10 and 0x14.
  - Required: `done` rises 2·(2+360) cycles after the trigger.
- Non-trigger stores: store 2 to 0x20, then 1 to 0x24.
  - Required: no `rd_en`, `tx` stays 1, `busy` stays 0.
- Retrigger during dump: store 1 to 0x20 mid-SEND.
  - Required: output identical to the basic case; no restart.
- Empty region: `SIG_BEGIN=SIG_END=0x10`; trigger.
  - Required: `done=1` one cycle later; `tx` never leaves 1; no `rd_en`.
- Reset mid-frame: assert `rst_n=0` during the third data bit of the first character.
  - Required: `tx=1`, `busy=0`, `done=0` with no clock edge.
  - Required: after release plus a new trigger, the full dump repeats correctly.
- Bit timing: `CLKS_PER_BIT=4`; measure the first character '0' (0x30).
  - Required: start bit low for 4 cycles.
  - Required: line pattern 0,0,0,0,1,1,0,0 for data bits 0–7, LSB first.
  - Required: stop bit high for 4 cycles; next start bit immediately follows.

Source files
------------

// File: rtl/sig_dump.sv
// rtl/sig_dump.sv - compliance signature dumper: snoops the tohost store, streams the signature region as hex text over UART
//
// Purpose:
//   Waits for the core to store 32'h1 to TOHOST. It then reads every word in
//   [SIG_BEGIN, SIG_END) through a spare synchronous BRAM read port. Each word is
//   sent on an 8N1 UART line as eight lowercase hex characters followed by '\n'.
//
// Ports:
//   clk      - single clock, rising edge
//   rst_n    - asynchronous active-low reset
//   st_en    - core full-word store strobe
//   st_addr  - store byte address
//   st_data  - store data
//   rd_en    - BRAM read strobe (one cycle per word)
//   rd_addr  - BRAM byte address, holds its last value between reads
//   rd_data  - BRAM read data, valid the cycle after rd_en
//   tx       - UART transmit line, idle high
//   busy     - dump in progress
//   done     - sticky, dump finished
module sig_dump #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [31:0] TOHOST       = 32'h0000_5000,
    parameter logic [31:0] SIG_BEGIN    = 32'h0000_5000,
    parameter logic [31:0] SIG_END      = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_en,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    // Frame layout within one character: bit 0 is the start bit, 1..8 are data
    // LSB first, 9 is the stop bit. Character 8 of each word is the newline.
    localparam logic [3:0] LAST_BIT  = 4'd9;
    localparam logic [3:0] LAST_CHAR = 4'd8;

    // An empty region is known at elaboration time; the trigger then goes
    // straight to DONE without touching the read port.
    localparam logic REGION_EMPTY = (SIG_BEGIN >= SIG_END);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0]   ptr_q;
    logic [31:0]   rd_addr_q;
    logic [31:0]   word_q;
    logic [3:0]    char_cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [BW-1:0] baud_cnt_q;

    logic          trigger;
    logic          bit_end;
    logic          char_end;
    logic          word_end;
    logic [31:0]   ptr_next;
    logic          more_words;
    logic [3:0]    nibble;
    logic [7:0]    hex_char;
    logic [7:0]    char_byte;
    logic [3:0]    data_idx;
    logic          frame_bit;

    assign trigger    = st_en && (st_addr == TOHOST) && (st_data == 32'h1);
    assign bit_end    = (baud_cnt_q == BAUD_LAST);
    assign char_end   = bit_end && (bit_cnt_q == LAST_BIT);
    assign word_end   = char_end && (char_cnt_q == LAST_CHAR);
    assign ptr_next   = ptr_q + 32'd4;
    assign more_words = (ptr_next < SIG_END);

    // The current character is always taken from the top nibble of word_q;
    // the word is shifted left by one nibble after each hex character.
    assign nibble    = word_q[31:28];
    assign hex_char  = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                        : (8'h57 + {4'h0, nibble});
    assign char_byte = (char_cnt_q == LAST_CHAR) ? 8'h0A : hex_char;
    assign data_idx  = bit_cnt_q - 4'd1;

    always_comb begin
        frame_bit = 1'b1;
        if (bit_cnt_q == 4'd0) begin
            frame_bit = 1'b0;
        end else if (bit_cnt_q == LAST_BIT) begin
            frame_bit = 1'b1;
        end else begin
            frame_bit = char_byte[data_idx[2:0]];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = REGION_EMPTY ? S_DONE : S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: state_d = S_SEND;
            S_SEND: begin
                if (word_end) begin
                    state_d = more_words ? S_READ : S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Word pointer, read address, shift word and the three frame counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= 32'h0;
            rd_addr_q  <= 32'h0;
            word_q     <= 32'h0;
            char_cnt_q <= 4'd0;
            bit_cnt_q  <= 4'd0;
            baud_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        ptr_q <= SIG_BEGIN;
                        if (!REGION_EMPTY) begin
                            rd_addr_q <= SIG_BEGIN;
                        end
                    end
                end
                S_WAIT: begin
                    word_q     <= rd_data;
                    char_cnt_q <= 4'd0;
                    bit_cnt_q  <= 4'd0;
                    baud_cnt_q <= '0;
                end
                S_SEND: begin
                    if (!bit_end) begin
                        baud_cnt_q <= baud_cnt_q + BW'(1);
                    end else begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q != LAST_BIT) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else begin
                            bit_cnt_q <= 4'd0;
                            if (char_cnt_q != LAST_CHAR) begin
                                char_cnt_q <= char_cnt_q + 4'd1;
                                word_q     <= {word_q[27:0], 4'h0};
                            end else begin
                                char_cnt_q <= 4'd0;
                                ptr_q      <= ptr_next;
                                // rd_addr only moves when another read follows,
                                // so it keeps the last read address in DONE.
                                if (more_words) begin
                                    rd_addr_q <= ptr_next;
                                end
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode from flops only, so reset forces them immediately.
    assign rd_en   = (state_q == S_READ);
    assign rd_addr = rd_addr_q;
    assign tx      = (state_q == S_SEND) ? frame_bit : 1'b1;
    assign busy    = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_SEND);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_sig_dump.sv
// tb/tb_sig_dump.sv - self-checking bench for sig_dump
module tb_sig_dump;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        st_en = 1'b0;
    logic [31:0] st_addr = 32'h0;
    logic [31:0] st_data = 32'h0;

    logic        rd_en_a, rd_en_b;
    logic [31:0] rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a = 32'h0;
    logic [31:0] rd_data_b = 32'h0;
    logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    sig_dump #(.CLKS_PER_BIT(CPB), .TOHOST(32'h20), .SIG_BEGIN(32'h10), .SIG_END(32'h18)) dut_a (
        .clk(clk), .rst_n(rst_n), .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    sig_dump #(.CLKS_PER_BIT(CPB), .TOHOST(32'h20), .SIG_BEGIN(32'h10), .SIG_END(32'h10)) dut_b (
        .clk(clk), .rst_n(rst_n), .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    byte         char_q[$];
    logic [31:0] addr_q[$];
    logic        trace[0:1023];
    int          rd_cnt_a = 0;
    logic        b_tx_low = 1'b0;
    logic        b_rd_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // BRAM model; garbage outside the valid cycle exposes mistimed capture.
    always @(posedge clk) begin
        if (rd_en_a) begin
            case (rd_addr_a)
                32'h10:  rd_data_a <= 32'hDEAD_BEEF;
                32'h14:  rd_data_a <= 32'h0000_001A;
                default: rd_data_a <= 32'h0;
            endcase
        end else begin
            rd_data_a <= 32'hA5A5_A5A5;
        end
        rd_data_b <= 32'h5A5A_5A5A;
    end

    // Read-port monitor: every rd_en pops the expected address.
    always @(negedge clk) begin
        if (rst_n && rd_en_a) begin
            rd_cnt_a++;
            if (addr_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got read at %0h expected none", rd_addr_a);
            end else begin
                chk("rd_addr", rd_addr_a, addr_q.pop_front());
            end
        end
        if (rd_en_b) b_rd_seen = 1'b1;
        if (tx_b !== 1'b1) b_tx_low = 1'b1;
    end

    // UART decoder on dut_a, mid-bit sampling, aborts on reset.
    logic       dec_active = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = 8'h0;

    always @(negedge clk) begin
        if (!rst_n) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (tx_a == 1'b0) begin
                dec_active = 1'b1;
                dec_cnt = 0;
            end
        end else begin
            dec_cnt++;
            for (int i = 0; i < 8; i++) begin
                if (dec_cnt == CPB * (i + 1) + CPB / 2) dec_byte[i] = tx_a;
            end
            if (dec_cnt == CPB * 9 + CPB / 2) begin
                chk("stop_bit", tx_a, 1'b1);
                if (char_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL uart_unexpected: got char %0h expected none", dec_byte);
                end else begin
                    chk("uart_char", dec_byte, char_q.pop_front());
                end
                dec_active = 1'b0;
            end
        end
    end

    // Runs one triggered dump. n counts negedges after the trigger edge:
    // n=1 is the READ cycle, n=3 the first start-bit cycle.
    task automatic run_dump(input int retrig_at, input int reset_at, output int done_n);
        string s;
        s = "deadbeef\n0000001a\n";
        for (int i = 0; i < s.len(); i++) char_q.push_back(s[i]);
        addr_q.push_back(32'h10);
        addr_q.push_back(32'h14);
        rd_cnt_a = 0;
        done_n = -1;
        @(negedge clk);
        chk("done_b_before_trigger", done_b, 1'b0);
        st_en = 1'b1;
        st_addr = 32'h20;
        st_data = 32'h1;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            st_en = (n == retrig_at);
            if (n < 1024) trace[n] = tx_a;
            if (n == 1) begin
                chk("busy_after_trigger", busy_a, 1'b1);
                chk("rd_en_after_trigger", rd_en_a, 1'b1);
                chk("empty_done_one_cycle", done_b, 1'b1);
            end
            if (n == 2) chk("rd_en_one_cycle", rd_en_a, 1'b0);
            if (n == reset_at) begin
                #1 rst_n = 1'b0;
                #1;
                chk("midframe_rst_tx", tx_a, 1'b1);
                chk("midframe_rst_busy", busy_a, 1'b0);
                chk("midframe_rst_done", done_a, 1'b0);
                return;
            end
            if (done_a) begin
                done_n = n;
                break;
            end
        end
    endtask

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[5];
    int   done_n;
    logic [31:0] act_bits, exp_bits32;
    logic [3:0]  grp;
    logic        zero_bits[8];

    initial begin
        vecs[0] = '{1'b1, 32'h20, 32'h2, 1'b0};
        vecs[1] = '{1'b1, 32'h24, 32'h1, 1'b0};
        vecs[2] = '{1'b0, 32'h20, 32'h1, 1'b0};
        vecs[3] = '{1'b1, 32'h21, 32'h1, 1'b0};
        vecs[4] = '{1'b1, 32'h20, 32'h101, 1'b0};
        zero_bits = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset values, before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tx", tx_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_rd_en", rd_en_a, 1'b0);
        chk("rst_rd_addr", rd_addr_a, 32'h0);
        chk("rst_done_b", done_b, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Stores that must not trigger
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            st_en = vecs[v].en;
            st_addr = vecs[v].addr;
            st_data = vecs[v].data;
            @(negedge clk);
            st_en = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            chk($sformatf("nontrig_busy_%0d", v), busy_a, vecs[v].exp_busy);
            chk($sformatf("nontrig_tx_%0d", v), tx_a, 1'b1);
            chk($sformatf("nontrig_done_b_%0d", v), done_b, 1'b0);
        end
        chk("nontrig_rd_count", rd_cnt_a, 0);

        // Basic dump with a retrigger in the middle of SEND
        run_dump(100, 0, done_n);
        // done rises 2*(2+90*CPB) edges after the trigger edge -> seen at n=725
        chk("done_latency", done_n, 725);
        #1;
        chk("rd_pulse_count", rd_cnt_a, 2);
        chk("chars_all_received", char_q.size(), 0);
        chk("done_busy_low", busy_a, 1'b0);
        chk("done_tx_high", tx_a, 1'b1);
        chk("idle_before_start", {trace[1], trace[2], trace[3]}, 3'b110);

        // Bit timing of the first '0' (first character of the second word)
        grp = {trace[365], trace[366], trace[367], trace[368]};
        chk("start_bit_4_low", grp, 4'b0000);
        for (int i = 0; i < 32; i++) begin
            act_bits[i] = trace[369 + i];
            exp_bits32[i] = zero_bits[i / 4];
        end
        chk("data_bits_0x30", act_bits, exp_bits32);
        grp = {trace[401], trace[402], trace[403], trace[404]};
        chk("stop_bit_4_high", grp, 4'b1111);
        grp = {trace[405], trace[406], trace[407], trace[408]};
        chk("next_start_follows", grp, 4'b0000);

        // Triggers in DONE are ignored
        @(negedge clk);
        st_en = 1'b1;
        st_addr = 32'h20;
        st_data = 32'h1;
        @(negedge clk);
        st_en = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("done_retrigger_ignored", {busy_a, done_a}, 2'b01);

        // Reset during the third data bit of the first character
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_dump(0, 16, done_n);
        char_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full dump after recovery
        run_dump(0, 0, done_n);
        chk("done_latency_after_rst", done_n, 725);
        #1;
        chk("rd_pulse_count_after_rst", rd_cnt_a, 2);
        chk("chars_after_rst", char_q.size(), 0);
        chk("addrs_after_rst", addr_q.size(), 0);

        chk("empty_tx_never_low", b_tx_low, 1'b0);
        chk("empty_no_rd_en", b_rd_seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
